exponent_scanner: RTL and testbench

//  Upstream exponent-bit source for the modular-exponentiation control FSM.
//  - Captures exponent d and finds its MSB index, published as r_t_sub_1 (= t-1).
//  - Then serves the current exponent bit r_d_0 and the iteration counter cnt.
//  - Each inc pulse from the control FSM shifts d right by one bit and increments cnt.

---
 rtl/rsa_pkg.sv | 14 +
 rtl/exponent_scanner_msb_encoder.sv | 21 ++
 rtl/exponent_scanner.sv | 108 ++++++++++
 tb/tb_exponent_scanner.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared types and helpers for the modular-exponentiation control slice.
package rsa_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        READY
    } exponent_scanner_states_e;

    function automatic int cnt_width(input int data_width);
        return $clog2(data_width);
    endfunction

endpackage

// File: rtl/exponent_scanner_msb_encoder.sv
// Combinational priority encoder: index of the highest set bit of one chunk.
module msb_encoder #(
    parameter int CHUNK = 32,
    localparam int IW = (CHUNK > 1) ? $clog2(CHUNK) : 1
) (
    input  logic [CHUNK-1:0] chunk,
    output logic [IW-1:0]    idx,
    output logic             nz
);

    // Ascending scan so the highest set bit is the last one written.
    always_comb begin
        idx = '0;
        for (int i = 0; i < CHUNK; i++) begin
            if (chunk[i]) idx = IW'(i);
        end
    end

    assign nz = |chunk;

endmodule

// File: rtl/exponent_scanner.sv
// Exponent-bit source: scans d for its MSB a chunk at a time, then shifts
// d out LSB-first on each inc while counting up to the MSB index.
//
//  state | meaning
//  IDLE  | nothing loaded, waiting for load
//  SCAN  | walking chunks from the top down looking for the MSB
//  READY | r_t_sub_1 valid, serving bits on inc
module exponent_scanner
    import rsa_pkg::*;
#(
    parameter int DATA_WIDTH = 1025,
    parameter int CHUNK      = 32,
    localparam int CW        = cnt_width(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ce,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] d,
    input  logic                  inc,
    output logic                  r_d_0,
    output logic [CW-1:0]         cnt,
    output logic [CW-1:0]         r_t_sub_1,
    output logic                  scan_done,
    output logic                  zero_exp
);

    localparam int NCHUNK = (DATA_WIDTH + CHUNK - 1) / CHUNK;
    localparam int PW     = NCHUNK * CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int IW     = (CHUNK > 1) ? $clog2(CHUNK) : 1;
    localparam logic [KW-1:0] K_TOP = KW'(NCHUNK - 1);

    exponent_scanner_states_e state;

    logic [DATA_WIDTH-1:0] sh;
    logic [PW-1:0]         copy;
    logic [KW-1:0]         k;
    logic [CHUNK-1:0]      chunk;
    logic [IW-1:0]         enc_idx;
    logic                  enc_nz;
    logic [CW-1:0]         hit_idx;

    // The copy is zero-padded to a whole number of chunks, so the top chunk
    // never reads beyond the exponent.
    assign chunk   = copy[k*CHUNK +: CHUNK];
    assign hit_idx = CW'(int'(k) * CHUNK + int'(enc_idx));
    assign r_d_0   = sh[0];

    msb_encoder #(
        .CHUNK (CHUNK)
    ) u_msb_encoder (
        .chunk (chunk),
        .idx   (enc_idx),
        .nz    (enc_nz)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sh        <= '0;
            copy      <= '0;
            k         <= '0;
            cnt       <= '0;
            r_t_sub_1 <= '0;
            scan_done <= 1'b0;
            zero_exp  <= 1'b0;
        end else if (ce) begin
            if (load) begin
                sh        <= d;
                copy      <= PW'(d);
                cnt       <= '0;
                k         <= K_TOP;
                scan_done <= 1'b0;
                zero_exp  <= 1'b0;
                state     <= SCAN;
            end else begin
                case (state)
                    IDLE: begin
                    end
                    SCAN: begin
                        if (enc_nz) begin
                            r_t_sub_1 <= hit_idx;
                            scan_done <= 1'b1;
                            state     <= READY;
                        end else if (k == '0) begin
                            r_t_sub_1 <= '0;
                            zero_exp  <= 1'b1;
                            scan_done <= 1'b1;
                            state     <= READY;
                        end else begin
                            k <= k - 1'b1;
                        end
                    end
                    READY: begin
                        // Saturating at the MSB keeps r_d_0 on the final 1 bit.
                        if (inc && (cnt != r_t_sub_1)) begin
                            sh  <= sh >> 1;
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_exponent_scanner.sv
// Scoreboard bench for exponent_scanner: directed cases plus random exponents.
module tb_exponent_scanner;

    localparam int DW = 1025;
    localparam int CH = 32;
    localparam int NC = 33;
    localparam int CW = 11;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ce;
    logic          load;
    logic [DW-1:0] d;
    logic          inc;
    logic          r_d_0;
    logic [CW-1:0] cnt;
    logic [CW-1:0] r_t_sub_1;
    logic          scan_done;
    logic          zero_exp;

    always #5 clk = ~clk;

    exponent_scanner #(
        .DATA_WIDTH (DW),
        .CHUNK      (CH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ce        (ce),
        .load      (load),
        .d         (d),
        .inc       (inc),
        .r_d_0     (r_d_0),
        .cnt       (cnt),
        .r_t_sub_1 (r_t_sub_1),
        .scan_done (scan_done),
        .zero_exp  (zero_exp)
    );

    typedef struct {
        int r;
        bit z;
        int lat;
        int c;
        bit b;
    } scan_exp_t;

    typedef struct {
        int c;
        bit b;
    } step_exp_t;

    scan_exp_t scan_q[$];
    step_exp_t step_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int load_edge = 0;
    bit inc_s = 1'b0;
    bit prev_done = 1'b0;

    // Reference model state
    logic [DW-1:0] md;
    int mmsb;
    int mn;
    bit mready;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int msb_of(input logic [DW-1:0] v);
        for (int i = DW - 1; i >= 0; i--) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    function automatic int lat_of(input logic [DW-1:0] v);
        if (v == '0) return NC;
        return NC - msb_of(v) / CH;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst_n && ce && load) load_edge = cyc;
        inc_s = rst_n && ce && inc && !load;
    end

    always @(negedge clk) begin
        if (inc_s) begin
            inc_s = 1'b0;
            if (step_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL step_unexpected: inc accepted with no expectation queued");
            end else begin
                step_exp_t e;
                e = step_q.pop_front();
                check("step_cnt", 32'(cnt), e.c);
                check("step_bit", 32'(r_d_0), 32'(e.b));
            end
        end
        if (scan_done && !prev_done) begin
            if (scan_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scan_unexpected: scan_done rose with no expectation queued");
            end else begin
                scan_exp_t s;
                s = scan_q.pop_front();
                check("scan_msb", 32'(r_t_sub_1), s.r);
                check("scan_zero", 32'(zero_exp), 32'(s.z));
                check("scan_latency", cyc - load_edge, s.lat);
                check("scan_cnt", 32'(cnt), s.c);
                check("scan_bit", 32'(r_d_0), 32'(s.b));
            end
        end
        prev_done = scan_done;
    end

    task automatic start_load(input logic [DW-1:0] v, input bit with_inc, input int extra);
        load = 1'b1;
        d = v;
        inc = with_inc;
        md = v;
        mmsb = msb_of(v);
        mn = 0;
        mready = 1'b0;
        scan_q.push_back('{mmsb, (v == '0), lat_of(v) + extra, 0, v[0]});
        @(negedge clk);
        load = 1'b0;
        inc = 1'b0;
    endtask

    task automatic wait_ready();
        int t;
        t = 0;
        while (!scan_done && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!scan_done) begin
            checks++;
            errors++;
            $display("FAIL scan_timeout: scan_done stayed 0 for %0d cycles", t);
        end
        mready = 1'b1;
    endtask

    task automatic do_inc();
        inc = 1'b1;
        if (mready && mn < mmsb) mn++;
        step_q.push_back('{mn, md[mn]});
        @(negedge clk);
        inc = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_r_d_0"}, 32'(r_d_0), 0);
        check({tag, "_cnt"}, 32'(cnt), 0);
        check({tag, "_r_t_sub_1"}, 32'(r_t_sub_1), 0);
        check({tag, "_scan_done"}, 32'(scan_done), 0);
        check({tag, "_zero_exp"}, 32'(zero_exp), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] v;
        logic [NC*CH-1:0] wide;
        int m;
        int n_inc;

        rst_n = 1'b0;
        ce = 1'b1;
        load = 1'b0;
        inc = 1'b0;
        d = '0;
        md = '0;
        mmsb = 0;
        mn = 0;
        mready = 1'b0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Reset asserted mid-scan; that scan never completes so nothing is queued.
        d = DW'(5);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check_all_zero("post_reset_idle");

        // 65537: inc during SCAN is ignored, then walk to the MSB and past it.
        start_load(DW'(65537), 1'b0, 0);
        do_inc();
        wait_ready();
        repeat (18) do_inc();

        // Top bit only: hit in the first chunk examined, long saturating walk.
        v = '0;
        v[DW-1] = 1'b1;
        start_load(v, 1'b0, 0);
        wait_ready();
        repeat (1030) do_inc();

        // Zero exponent.
        start_load('0, 1'b0, 0);
        wait_ready();
        do_inc();

        // load and inc together in READY: load wins.
        start_load(DW'(65537), 1'b0, 0);
        wait_ready();
        repeat (3) do_inc();
        start_load(DW'(3), 1'b1, 0);
        wait_ready();
        repeat (2) do_inc();

        // Five ce-low cycles mid-scan delay completion by exactly five edges.
        start_load(DW'(5), 1'b0, 5);
        repeat (10) @(negedge clk);
        ce = 1'b0;
        repeat (5) @(negedge clk);
        ce = 1'b1;
        wait_ready();
        do_inc();

        for (int s = 0; s < 1000; s++) begin
            for (int w = 0; w < NC; w++) wide[w*CH +: CH] = $urandom;
            v = wide[DW-1:0];
            if ($urandom_range(0, 49) == 0) begin
                v = '0;
            end else begin
                m = $urandom_range(0, DW - 1);
                for (int i = m + 1; i < DW; i++) v[i] = 1'b0;
                v[m] = 1'b1;
            end
            start_load(v, 1'b0, 0);
            if ($urandom_range(0, 7) == 0) do_inc();
            wait_ready();
            n_inc = $urandom_range(0, 6);
            for (int j = 0; j < n_inc; j++) do_inc();
        end

        repeat (3) @(negedge clk);
        check("scan_q_drained", scan_q.size(), 0);
        check("step_q_drained", step_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
